// File: rtl/avg_fetch_pkg.sv
// Shared types and helpers for the AVG fetch/sequencer stage.
// Word assembly here must match the byte order the decoder expects.
package avg_fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD0   = 3'd1,
        ST_RD1   = 3'd2,
        ST_CAP   = 3'd3,
        ST_VALID = 3'd4
    } fetch_state_t;

    localparam logic [15:0] START_PC_DEFAULT = 16'h0000;
    localparam logic [15:0] PC_STEP_DEFAULT  = 16'h0002;

    // Vector memory is little-endian per word; the decoder sees bytes high-first.
    function automatic logic [31:0] assemble_inst(input logic [15:0] w0, input logic [15:0] w1);
        return {w0[7:0], w0[15:8], w1[7:0], w1[15:8]};
    endfunction

endpackage

// File: rtl/avg_fetch_if.sv
// Vector-memory read port and decoder handshake between fetch stage and its neighbours.
interface avg_fetch_if;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready;
    logic [2:0]  dcd_pc_offset;
    logic        dcd_jmp;
    logic        dcd_jsr;
    logic        dcd_ret;
    logic        dcd_halt;
    logic [15:0] dcd_jump_addr;

    modport master (
        output mem_rd, mem_addr, inst, inst_valid,
        input  mem_rdata, inst_ready, dcd_pc_offset, dcd_jmp, dcd_jsr, dcd_ret,
               dcd_halt, dcd_jump_addr
    );

    modport slave (
        input  mem_rd, mem_addr, inst, inst_valid,
        output mem_rdata, inst_ready, dcd_pc_offset, dcd_jmp, dcd_jsr, dcd_ret,
               dcd_halt, dcd_jump_addr
    );
endinterface

// File: rtl/avg_ret_stack.sv
// JSR return-address LIFO; the caller guards push-at-full / pop-at-empty, the
// stack also ignores them so its pointer can never leave 0..DEPTH.
module avg_ret_stack #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  logic [15:0] push_data,
    output logic [15:0] top,
    output logic        full,
    output logic        empty
);
    localparam int AW  = $clog2(DEPTH);
    localparam int SPW = AW + 1;

    logic [15:0]    entry_r [DEPTH];
    logic [SPW-1:0] sp_r;
    logic [AW-1:0]  top_idx_s;

    assign full      = (sp_r == SPW'(DEPTH));
    assign empty     = (sp_r == SPW'(0));
    assign top_idx_s = sp_r[AW-1:0] - AW'(1);
    assign top       = entry_r[top_idx_s];

    // Stack pointer and storage update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_r <= SPW'(0);
            for (int i = 0; i < DEPTH; i++) begin
                entry_r[i] <= 16'h0000;
            end
        end else if (push && !full) begin
            entry_r[sp_r[AW-1:0]] <= push_data;
            sp_r                  <= sp_r + SPW'(1);
        end else if (pop && !empty) begin
            sp_r <= sp_r - SPW'(1);
        end else begin
            sp_r <= sp_r;
        end
    end

endmodule

// File: rtl/avg_fetch.sv
// AVG fetch/sequencer: reads two words per instruction, hands the assembled word to
// the decoder and steps the PC (sequential/jump/JSR/RTS/halt) when it is accepted.
module avg_fetch
    import avg_fetch_pkg::*;
#(
    parameter int          STACK_DEPTH = 4,
    parameter logic [15:0] START_PC    = START_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        go,
    output logic        busy,
    output logic        halted,
    output logic        stk_err,
    output logic [15:0] pc,
    avg_fetch_if.master bus
);
    fetch_state_t state_r, state_s;
    logic [15:0]  pc_r, pc_s;
    logic [15:0]  w0_r, w0_s;
    logic [31:0]  inst_r, inst_s;
    logic [15:0]  mem_addr_r, mem_addr_s;
    logic         mem_rd_r, mem_rd_s;
    logic         inst_valid_r, inst_valid_s;
    logic         busy_r, busy_s;
    logic         halted_r, halted_s;
    logic         stk_err_r, stk_err_s;
    logic         push_s, pop_s;
    logic         stk_full_s, stk_empty_s;
    logic [15:0]  stk_top_s;
    logic [15:0]  off_s, seq_pc_s, jump_pc_s, pc_step_s;

    // A zero offset would stall on the same instruction forever, so it steps one word.
    assign off_s     = (bus.dcd_pc_offset == 3'd0) ? PC_STEP_DEFAULT : {13'd0, bus.dcd_pc_offset};
    assign seq_pc_s  = pc_r + off_s;
    assign jump_pc_s = {bus.dcd_jump_addr[15:1], 1'b0};
    assign pc_step_s = pc_r + PC_STEP_DEFAULT;

    avg_ret_stack #(.DEPTH(STACK_DEPTH)) u_ret_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (seq_pc_s),
        .top       (stk_top_s),
        .full      (stk_full_s),
        .empty     (stk_empty_s)
    );

    // Next-state and PC/flag update; decoder controls matter only on an accept in VALID.
    always_comb begin
        state_s   = state_r;
        pc_s      = pc_r;
        w0_s      = w0_r;
        inst_s    = inst_r;
        busy_s    = busy_r;
        halted_s  = halted_r;
        stk_err_s = stk_err_r;
        push_s    = 1'b0;
        pop_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (go) begin
                    pc_s      = START_PC;
                    halted_s  = 1'b0;
                    stk_err_s = 1'b0;
                    busy_s    = 1'b1;
                    state_s   = ST_RD0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RD0: state_s = ST_RD1;
            ST_RD1: begin
                w0_s    = bus.mem_rdata;
                state_s = ST_CAP;
            end
            ST_CAP: begin
                inst_s  = assemble_inst(w0_r, bus.mem_rdata);
                state_s = ST_VALID;
            end
            ST_VALID: begin
                if (!bus.inst_ready) begin
                    state_s = ST_VALID;
                end else if (bus.dcd_halt) begin
                    halted_s = 1'b1;
                    busy_s   = 1'b0;
                    state_s  = ST_IDLE;
                end else if (bus.dcd_jsr) begin
                    if (stk_full_s) begin
                        stk_err_s = 1'b1;
                        busy_s    = 1'b0;
                        state_s   = ST_IDLE;
                    end else begin
                        push_s  = 1'b1;
                        pc_s    = jump_pc_s;
                        state_s = ST_RD0;
                    end
                end else if (bus.dcd_jmp) begin
                    pc_s    = jump_pc_s;
                    state_s = ST_RD0;
                end else if (bus.dcd_ret) begin
                    if (stk_empty_s) begin
                        stk_err_s = 1'b1;
                        busy_s    = 1'b0;
                        state_s   = ST_IDLE;
                    end else begin
                        pop_s   = 1'b1;
                        pc_s    = stk_top_s;
                        state_s = ST_RD0;
                    end
                end else begin
                    pc_s    = seq_pc_s;
                    state_s = ST_RD0;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Bus outputs are registered, so they are derived from the state being entered.
    always_comb begin
        mem_rd_s     = (state_s == ST_RD0) || (state_s == ST_RD1);
        inst_valid_s = (state_s == ST_VALID);
        if (state_s == ST_RD0) begin
            mem_addr_s = {pc_s[15:1], 1'b0};
        end else if (state_s == ST_RD1) begin
            mem_addr_s = {pc_step_s[15:1], 1'b0};
        end else begin
            mem_addr_s = mem_addr_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            pc_r         <= START_PC;
            w0_r         <= 16'h0000;
            inst_r       <= 32'h0000_0000;
            mem_addr_r   <= 16'h0000;
            mem_rd_r     <= 1'b0;
            inst_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            halted_r     <= 1'b0;
            stk_err_r    <= 1'b0;
        end else begin
            state_r      <= state_s;
            pc_r         <= pc_s;
            w0_r         <= w0_s;
            inst_r       <= inst_s;
            mem_addr_r   <= mem_addr_s;
            mem_rd_r     <= mem_rd_s;
            inst_valid_r <= inst_valid_s;
            busy_r       <= busy_s;
            halted_r     <= halted_s;
            stk_err_r    <= stk_err_s;
        end
    end

    assign busy           = busy_r;
    assign halted         = halted_r;
    assign stk_err        = stk_err_r;
    assign pc             = pc_r;
    assign bus.mem_rd     = mem_rd_r;
    assign bus.mem_addr   = mem_addr_r;
    assign bus.inst       = inst_r;
    assign bus.inst_valid = inst_valid_r;

endmodule

// File: tb/tb_avg_fetch.sv
// Directed bench for avg_fetch: a vector table of decoder responses plus hand-written
// sequences for fetch latency, backpressure and mid-fetch reset.
module tb_avg_fetch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        go = 1'b0;
    logic        busy, halted, stk_err;
    logic [15:0] pc;
    logic [15:0] mem [0:1023];
    int          total = 0;
    int          bad = 0;

    avg_fetch_if bus_if ();

    avg_fetch #(.STACK_DEPTH(4), .START_PC(16'h0000)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .go      (go),
        .busy    (busy),
        .halted  (halted),
        .stk_err (stk_err),
        .pc      (pc),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus_if.mem_rd) bus_if.mem_rdata <= mem[bus_if.mem_addr[10:1]];
    end

    typedef struct {
        logic        do_go;
        logic [2:0]  off;
        logic        jmp, jsr, ret, halt;
        logic [15:0] jaddr;
        logic [31:0] exp_inst;
        logic [15:0] exp_pc;
        logic        exp_busy, exp_halted, exp_err;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic pulse_go();
        @(negedge clk);
        go = 1'b1;
        @(posedge clk);
        #1 go = 1'b0;
    endtask

    task automatic step(input vec_t v, input int idx);
        bit found = 1'b0;
        if (v.do_go) pulse_go();
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            found = bus_if.inst_valid;
        end
        if (!found) begin
            chk($sformatf("v%0d_valid_timeout", idx), 32'd0, 32'd1);
        end else begin
            chk($sformatf("v%0d_inst", idx), bus_if.inst, v.exp_inst);
            bus_if.dcd_pc_offset = v.off;
            bus_if.dcd_jmp       = v.jmp;
            bus_if.dcd_jsr       = v.jsr;
            bus_if.dcd_ret       = v.ret;
            bus_if.dcd_halt      = v.halt;
            bus_if.dcd_jump_addr = v.jaddr;
            bus_if.inst_ready    = 1'b1;
            @(posedge clk);
            #1;
            bus_if.inst_ready = 1'b0;
            {bus_if.dcd_jmp, bus_if.dcd_jsr, bus_if.dcd_ret, bus_if.dcd_halt} = 4'b0000;
            chk($sformatf("v%0d_pc", idx), {16'h0000, pc}, {16'h0000, v.exp_pc});
            chk($sformatf("v%0d_busy", idx), {31'd0, busy}, {31'd0, v.exp_busy});
            chk($sformatf("v%0d_halted", idx), {31'd0, halted}, {31'd0, v.exp_halted});
            chk($sformatf("v%0d_stk_err", idx), {31'd0, stk_err}, {31'd0, v.exp_err});
            chk($sformatf("v%0d_mem_rd", idx), {31'd0, bus_if.mem_rd}, {31'd0, v.exp_busy});
            if (v.exp_busy) begin
                chk($sformatf("v%0d_mem_addr", idx), {16'h0000, bus_if.mem_addr},
                    {16'h0000, v.exp_pc[15:1], 1'b0});
            end
        end
    endtask

    initial begin
        logic [31:0] held;
        vec_t bp;
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        mem[16'h0000 >> 1] = 16'h6180;
        mem[16'h0004 >> 1] = 16'h2000;
        mem[16'h0010 >> 1] = 16'hBEEF;
        mem[16'h0012 >> 1] = 16'h0001;
        mem[16'h0100 >> 1] = 16'h1234;
        mem[16'h0102 >> 1] = 16'hABCD;
        mem[16'h0104 >> 1] = 16'h5678;
        bus_if.mem_rdata     = 16'h0000;
        bus_if.inst_ready    = 1'b0;
        bus_if.dcd_pc_offset = 3'd2;
        bus_if.dcd_jmp       = 1'b0;
        bus_if.dcd_jsr       = 1'b0;
        bus_if.dcd_ret       = 1'b0;
        bus_if.dcd_halt      = 1'b0;
        bus_if.dcd_jump_addr = 16'h0000;

        //            go    off   jmp   jsr   ret   halt  jaddr     inst            pc        busy  hlt   err
        vecs[0]  = '{1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h8061_0000, 16'h0002, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 32'h0000_0020, 16'h0002, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0100, 32'h8061_0000, 16'h0100, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h3412_CDAB, 16'h0102, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0011, 32'hCDAB_7856, 16'h0010, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0200, 32'hEFBE_0100, 16'h0200, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 32'h0000_0000, 16'h0012, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 32'h0100_0000, 16'h0012, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0300, 32'h8061_0000, 16'h0300, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0300, 32'h0000_0000, 16'h0300, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0300, 32'h0000_0000, 16'h0300, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0300, 32'h0000_0000, 16'h0300, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0300, 32'h0000_0000, 16'h0300, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0400, 32'h8061_0000, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0100, 32'h8061_0000, 16'h0100, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 32'h3412_CDAB, 16'h0100, 1'b0, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_pc", {16'h0000, pc}, 32'h0000_0000);
        chk("rst_inst_valid", {31'd0, bus_if.inst_valid}, 32'd0);
        chk("rst_mem_rd", {31'd0, bus_if.mem_rd}, 32'd0);
        rst_n = 1'b1;

        // Fetch latency from go to inst_valid.
        pulse_go();
        @(negedge clk);
        chk("lat_rd0_mem_rd", {31'd0, bus_if.mem_rd}, 32'd1);
        chk("lat_rd0_addr", {16'h0000, bus_if.mem_addr}, 32'h0000_0000);
        chk("lat_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("lat_rd1_addr", {16'h0000, bus_if.mem_addr}, 32'h0000_0002);
        chk("lat_rd1_valid", {31'd0, bus_if.inst_valid}, 32'd0);
        @(negedge clk);
        chk("lat_cap_mem_rd", {31'd0, bus_if.mem_rd}, 32'd0);
        chk("lat_cap_valid", {31'd0, bus_if.inst_valid}, 32'd0);
        @(negedge clk);
        chk("lat_valid", {31'd0, bus_if.inst_valid}, 32'd1);
        chk("lat_inst", bus_if.inst, 32'h8061_0000);

        for (int i = 0; i < 16; i++) step(vecs[i], i);

        // Backpressure: decoder stalls, go is pulsed while busy.
        pulse_go();
        repeat (3) @(negedge clk);
        held = 32'h8061_0000;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            go = (c == 4);
            chk("bp_inst", bus_if.inst, held);
            chk("bp_valid", {31'd0, bus_if.inst_valid}, 32'd1);
            chk("bp_mem_rd", {31'd0, bus_if.mem_rd}, 32'd0);
            chk("bp_pc", {16'h0000, pc}, 32'h0000_0000);
        end
        @(negedge clk);
        go = 1'b0;
        chk("bp_busy_after_go", {31'd0, busy}, 32'd1);
        chk("bp_pc_after_go", {16'h0000, pc}, 32'h0000_0000);
        bp = '{1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 32'h8061_0000, 16'h0000, 1'b0, 1'b1, 1'b0};
        step(bp, 100);

        // Reset asserted while the second word is being read.
        pulse_go();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_busy", {31'd0, busy}, 32'd0);
        chk("mr_mem_rd", {31'd0, bus_if.mem_rd}, 32'd0);
        chk("mr_inst", bus_if.inst, 32'h0000_0000);
        chk("mr_halted", {31'd0, halted}, 32'd0);
        chk("mr_pc", {16'h0000, pc}, 32'h0000_0000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("mr_idle_valid", {31'd0, bus_if.inst_valid}, 32'd0);
        pulse_go();
        @(negedge clk);
        chk("mr_restart_addr", {16'h0000, bus_if.mem_addr}, 32'h0000_0000);
        chk("mr_restart_rd", {31'd0, bus_if.mem_rd}, 32'd1);
        step(bp, 101);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
